operand_fetch_unit: RTL and testbench
=====================================

OPERAND_FETCH_UNIT -- requirements
Module: operand_fetch_unit

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; REG_AW, default 4, register-address width; NUM_FWD, default 3, bypass sources (index 0 youngest); CTRL_W, default 22, control-word width.
REQ-002 Ports, clock and reset first: clk in 1 clock; rst_n in 1 reset; one clock, reset asynchronous, active-low.
REQ-003 in_valid in 1 upstream instruction valid; in_ready out 1 stage accepts.
REQ-004 pc_in in XLEN; inst_in in 32; ctrl_in in CTRL_W, decoded control word.
REQ-005 rf_raddr1, rf_raddr2 out REG_AW, combinational regfile read addresses; rf_rdata1, rf_rdata2 in XLEN, same-cycle read data.
REQ-006 fwd_valid in NUM_FWD; fwd_busy in NUM_FWD, destination result not yet available; fwd_addr in NUM_FWD*REG_AW; fwd_data in NUM_FWD*XLEN.
REQ-007 flush in 1, kill held and incoming instruction.
REQ-008 out_valid out 1; out_ready in 1; out_pc out XLEN; out_inst out 32; out_ctrl out CTRL_W; out_a out XLEN; out_b out XLEN; out_op2 out XLEN, store data; out_immx out XLEN; out_btarget out XLEN; all registered.

Function
REQ-009 rf_raddr1 SHALL be all-ones (return-address register) when ctrl_in[IS_RET] else inst_in[21:18]; rf_raddr2 SHALL be inst_in[25:22] when ctrl_in[IS_ST] else inst_in[17:14].
REQ-010 Per operand, the first i (lowest index) with fwd_valid[i] and fwd_addr[i]==read address SHALL supply fwd_data[i]; none matching SHALL supply rf_rdata.
REQ-011 Hazard SHALL be asserted when in_valid and the winning matching source (REQ-010 order) has fwd_busy set for either operand.
REQ-012 Immediate SHALL use inst_in[17:16]: 00 sign-extend inst_in[15:0]; 01 zero-extend; 10 inst_in[15:0] shifted left 16; 11 zero.
REQ-013 Branch target SHALL be pc_in + (sign-extended inst_in[26:0] shifted left 2), modulo 2^XLEN.
REQ-014 out_a SHALL be bypassed operand 1; out_op2 bypassed operand 2; out_b SHALL be immediate when ctrl_in[IS_IMM] else bypassed operand 2.
REQ-015 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-016 Capture: in_valid && in_ready SHALL load all payload registers and set out_valid next cycle; latency exactly one cycle.
REQ-017 out_valid && !out_ready SHALL hold every output stable.
REQ-018 out_valid && out_ready with no capture SHALL clear out_valid next cycle (bubble); hazard therefore inserts bubbles until fwd_busy clears.
REQ-019 flush SHALL clear out_valid next cycle regardless of out_ready, in_valid or hazard; flush has priority over capture.
REQ-020 Simultaneous drain and capture SHALL keep out_valid high with new payload (full throughput, one instruction per cycle).
REQ-021 Payload registers SHALL not change when no capture occurs.

Reset
REQ-022 rst_n low SHALL asynchronously clear out_valid and all payload outputs to zero.
REQ-023 Reset mid-stall or mid-hold SHALL discard the held instruction; first capture possible on the first rising clk after rst_n deasserts.

Structure
REQ-024 Package of_pkg SHALL hold control-bit indices IS_ST=0, IS_RET=4, IS_IMM=5, modifier encodings, and the return-address register index.
REQ-025 One sub-module operand_bypass (priority match of one read address over NUM_FWD sources, outputs data and busy-hit) SHALL be instantiated twice.

Verification
REQ-026 Imm: inst modifiers 00, imm 0x8001, IS_IMM=1 -> out_b=0xFFFF8001, out_valid one cycle later; modifier 10 -> 0x80010000.
REQ-027 Branch: pc_in=0x100, inst[26:0]=0x7FFFFFF -> out_btarget=0x0FC.
REQ-028 Bypass priority: rs1=3, fwd0 and fwd2 both addr 3 valid, data 0xAA/0xCC -> out_a=0xAA; only fwd2 -> 0xCC; none -> rf_rdata1.
REQ-029 Load-use: fwd_busy[0]=1 matching rs2 for 2 cycles -> in_ready=0 two cycles, out_valid low after drain, capture on third cycle with fwd_data[0].
REQ-030 Backpressure plus flush: out_ready=0 for 3 cycles -> outputs stable; flush asserted with in_valid=1 -> out_valid=0 next cycle, nothing captured.
REQ-031 Reset: rst_n low mid-hold, asynchronous -> out_valid=0 and payload zero without clk edge.

Source files
------------

// File: rtl/of_pkg.sv
// Shared definitions for the operand fetch stage: control-word bit positions,
// immediate modifier encodings and the return-address register index.
package of_pkg;

    // Bit positions inside the decoded control word
    localparam int IS_ST  = 0;
    localparam int IS_RET = 4;
    localparam int IS_IMM = 5;

    // Immediate modifier taken from inst[17:16]
    typedef enum logic [1:0] {
        IMM_SEXT = 2'b00,
        IMM_ZEXT = 2'b01,
        IMM_HI16 = 2'b10,
        IMM_ZERO = 2'b11
    } imm_mod_e;

    // Return-address register is the highest register: all ones at any address width
    function automatic int unsigned ra_reg_idx(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Priority bypass match for one register read port. The lowest-index (youngest)
// valid source whose destination equals the read address supplies the data;
// otherwise the register file value passes through.
module operand_bypass #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 4,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_AW-1:0]         raddr,
    input  logic [XLEN-1:0]           rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_busy,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]           data,
    output logic                      busy_hit
);

    // Scan oldest to youngest so the youngest match overwrites and wins
    always_comb begin
        data     = rf_rdata;
        busy_hit = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == raddr)) begin
                data     = fwd_data[i*XLEN +: XLEN];
                busy_hit = fwd_busy[i];
            end
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: drives register-file read addresses, resolves bypasses,
// expands the immediate, computes the branch target and registers the result
// behind a valid/ready handshake with one cycle of latency.
module operand_fetch_unit
    import of_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 4,
    parameter int NUM_FWD = 3,
    parameter int CTRL_W  = 22
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           pc_in,
    input  logic [31:0]               inst_in,
    input  logic [CTRL_W-1:0]         ctrl_in,
    output logic [REG_AW-1:0]         rf_raddr1,
    output logic [REG_AW-1:0]         rf_raddr2,
    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_busy,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_inst,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [XLEN-1:0]           out_a,
    output logic [XLEN-1:0]           out_b,
    output logic [XLEN-1:0]           out_op2,
    output logic [XLEN-1:0]           out_immx,
    output logic [XLEN-1:0]           out_btarget
);

    localparam logic [REG_AW-1:0] RA_ADDR = REG_AW'(ra_reg_idx(REG_AW));

    // Immediate expansion selected by the two modifier bits
    function automatic logic [XLEN-1:0] imm_expand(input logic [1:0] mod, input logic [15:0] imm);
        logic signed [XLEN-1:0] simm;
        logic [XLEN-1:0]        res;
        simm = XLEN'($signed(imm));
        case (imm_mod_e'(mod))
            IMM_SEXT: res = $unsigned(simm);
            IMM_ZEXT: res = XLEN'(imm);
            IMM_HI16: res = XLEN'({imm, 16'h0000});
            default:  res = '0;
        endcase
        return res;
    endfunction

    // PC-relative target: signed word displacement, wraps modulo 2^XLEN
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc, input logic [26:0] disp);
        logic signed [XLEN-1:0] off;
        off = XLEN'($signed(disp));
        off = off <<< 2;
        return pc + $unsigned(off);
    endfunction

    // ---- stage p0: combinational operand resolution ----
    logic [XLEN-1:0] op1_p0;
    logic [XLEN-1:0] op2_p0;
    logic            busy1_p0;
    logic            busy2_p0;
    logic [XLEN-1:0] imm_p0;
    logic [XLEN-1:0] bt_p0;
    logic            hazard_p0;
    logic            capture_p0;

    // Read-address selection: returns read the link register, stores read rs2 from [25:22]
    always_comb begin
        rf_raddr1 = ctrl_in[IS_RET] ? RA_ADDR : inst_in[21:18];
        rf_raddr2 = ctrl_in[IS_ST]  ? inst_in[25:22] : inst_in[17:14];
    end

    operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_byp1 (
        .raddr     (rf_raddr1),
        .rf_rdata  (rf_rdata1),
        .fwd_valid (fwd_valid),
        .fwd_busy  (fwd_busy),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .data      (op1_p0),
        .busy_hit  (busy1_p0)
    );

    operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_byp2 (
        .raddr     (rf_raddr2),
        .rf_rdata  (rf_rdata2),
        .fwd_valid (fwd_valid),
        .fwd_busy  (fwd_busy),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .data      (op2_p0),
        .busy_hit  (busy2_p0)
    );

    // Handshake: stall on a busy bypass source, never accept during a flush
    always_comb begin
        imm_p0     = imm_expand(inst_in[17:16], inst_in[15:0]);
        bt_p0      = branch_target(pc_in, inst_in[26:0]);
        hazard_p0  = in_valid && (busy1_p0 || busy2_p0);
        in_ready   = (!out_valid || out_ready) && !hazard_p0 && !flush;
        capture_p0 = in_valid && in_ready;
    end

    // ---- stage p1: registered outputs ----
    logic                  vld_p1;
    logic [XLEN-1:0]       pc_p1;
    logic [31:0]           inst_p1;
    logic [CTRL_W-1:0]     ctrl_p1;
    logic [XLEN-1:0]       a_p1;
    logic [XLEN-1:0]       b_p1;
    logic [XLEN-1:0]       op2_p1;
    logic [XLEN-1:0]       immx_p1;
    logic [XLEN-1:0]       bt_p1;

    // Output valid: flush wins, then capture, then drain to a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (capture_p0) begin
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Payload loads only on capture and otherwise holds its value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p1   <= '0;
            inst_p1 <= '0;
            ctrl_p1 <= '0;
            a_p1    <= '0;
            b_p1    <= '0;
            op2_p1  <= '0;
            immx_p1 <= '0;
            bt_p1   <= '0;
        end else if (capture_p0) begin
            pc_p1   <= pc_in;
            inst_p1 <= inst_in;
            ctrl_p1 <= ctrl_in;
            a_p1    <= op1_p0;
            b_p1    <= ctrl_in[IS_IMM] ? imm_p0 : op2_p0;
            op2_p1  <= op2_p0;
            immx_p1 <= imm_p0;
            bt_p1   <= bt_p0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_pc      = pc_p1;
    assign out_inst    = inst_p1;
    assign out_ctrl    = ctrl_p1;
    assign out_a       = a_p1;
    assign out_b       = b_p1;
    assign out_op2     = op2_p1;
    assign out_immx    = immx_p1;
    assign out_btarget = bt_p1;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Self-checking bench for operand_fetch_unit: directed scenarios followed by a
// randomized run against a behavioural model of the stage.
module tb_operand_fetch_unit;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 4;
    localparam int NUM_FWD = 3;
    localparam int CTRL_W  = 22;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [XLEN-1:0]           pc_in;
    logic [31:0]               inst_in;
    logic [CTRL_W-1:0]         ctrl_in;
    logic [REG_AW-1:0]         rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]           rf_rdata1, rf_rdata2;
    logic [NUM_FWD-1:0]        fwd_valid, fwd_busy;
    logic [NUM_FWD*REG_AW-1:0] fwd_addr;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_pc;
    logic [31:0]               out_inst;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [XLEN-1:0]           out_a, out_b, out_op2, out_immx, out_btarget;

    logic [REG_AW-1:0] fa [NUM_FWD];
    logic [XLEN-1:0]   fd [NUM_FWD];
    logic [XLEN-1:0]   rf_mem [16];

    int errors = 0;
    int checks = 0;

    // Model state for the registered outputs
    logic              m_valid;
    logic [31:0]       m_pc, m_inst, m_a, m_b, m_op2, m_immx, m_bt;
    logic [CTRL_W-1:0] m_ctrl;

    always #5 clk = ~clk;

    always_comb begin
        fwd_addr = '0;
        fwd_data = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            fwd_addr[i*REG_AW +: REG_AW] = fa[i];
            fwd_data[i*XLEN +: XLEN]     = fd[i];
        end
    end

    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    operand_fetch_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pc_in       (pc_in),
        .inst_in     (inst_in),
        .ctrl_in     (ctrl_in),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .fwd_valid   (fwd_valid),
        .fwd_busy    (fwd_busy),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ctrl    (out_ctrl),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_op2     (out_op2),
        .out_immx    (out_immx),
        .out_btarget (out_btarget)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        pc_in     = '0;
        inst_in   = '0;
        ctrl_in   = '0;
        fwd_valid = '0;
        fwd_busy  = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            fa[i] = '0;
            fd[i] = '0;
        end
    endtask

    // First valid source in index order supplies the value, else the register file
    task automatic pick(input logic [3:0] a, output logic [31:0] v, output logic busy);
        bit found;
        found = 0;
        v     = rf_mem[a];
        busy  = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!found && fwd_valid[i] && fa[i] == a) begin
                v     = fd[i];
                busy  = fwd_busy[i];
                found = 1;
            end
        end
    endtask

    function automatic logic [31:0] model_imm(input logic [31:0] inst);
        logic [31:0] imm;
        imm = {16'h0000, inst[15:0]};
        case (inst[17:16])
            2'b00:   return inst[15] ? (imm | 32'hFFFF_0000) : imm;
            2'b01:   return imm;
            2'b10:   return imm * 32'd65536;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_bt(input logic [31:0] pc, input logic [31:0] inst);
        longint off;
        longint sum;
        off = longint'(inst[26:0]);
        if (inst[26]) off = off - (64'sd1 <<< 27);
        sum = longint'(pc) + off * 4;
        return sum[31:0];
    endfunction

    // Check combinational outputs and advance the model by one clock
    task automatic model_cycle();
        logic [3:0]  a1, a2;
        logic [31:0] v1, v2;
        logic        b1, b2, hz, rdy;
        a1 = ctrl_in[4] ? 4'hF : inst_in[21:18];
        a2 = ctrl_in[0] ? inst_in[25:22] : inst_in[17:14];
        pick(a1, v1, b1);
        pick(a2, v2, b2);
        hz  = in_valid && (b1 || b2);
        rdy = (!m_valid || out_ready) && !hz && !flush;
        chk("rnd_raddr1", 32'(rf_raddr1), 32'(a1));
        chk("rnd_raddr2", 32'(rf_raddr2), 32'(a2));
        chk("rnd_in_ready", 32'(in_ready), 32'(rdy));
        if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_pc    = pc_in;
            m_inst  = inst_in;
            m_ctrl  = ctrl_in;
            m_a     = v1;
            m_op2   = v2;
            m_immx  = model_imm(inst_in);
            m_b     = ctrl_in[5] ? m_immx : v2;
            m_bt    = model_bt(pc_in, inst_in);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        chk("rnd_out_valid", 32'(out_valid), 32'(m_valid));
        chk("rnd_out_pc", out_pc, m_pc);
        chk("rnd_out_inst", out_inst, m_inst);
        chk("rnd_out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
        chk("rnd_out_a", out_a, m_a);
        chk("rnd_out_b", out_b, m_b);
        chk("rnd_out_op2", out_op2, m_op2);
        chk("rnd_out_immx", out_immx, m_immx);
        chk("rnd_out_btarget", out_btarget, m_bt);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
        rf_mem[3] = 32'h1111_1111;
        rst_n = 1'b0;
        set_idle();

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_a", out_a, 32'h0);
        chk("rst_out_b", out_b, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_btarget", out_btarget, 32'h0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Immediate sign-extend with one-cycle latency, then high-half shift
        in_valid = 1'b1;
        inst_in  = 32'h0000_8001;
        ctrl_in  = CTRL_W'(32'h20);
        #1;
        chk("imm_in_ready", 32'(in_ready), 32'h1);
        chk("imm_not_yet_valid", 32'(out_valid), 32'h0);
        tick();
        chk("imm_valid", 32'(out_valid), 32'h1);
        chk("imm_sext_b", out_b, 32'hFFFF_8001);
        chk("imm_sext_immx", out_immx, 32'hFFFF_8001);
        inst_in = 32'h0002_8001;
        tick();
        chk("imm_hi16_b", out_b, 32'h8001_0000);

        // Branch target with negative displacement
        ctrl_in = '0;
        pc_in   = 32'h100;
        inst_in = 32'h07FF_FFFF;
        tick();
        chk("br_target", out_btarget, 32'h0000_00FC);
        chk("br_pc", out_pc, 32'h100);

        // Bypass priority on rs1 = 3
        pc_in     = 32'h0;
        inst_in   = 32'h000C_0000;
        fwd_valid = 3'b101;
        fa[0] = 4'd3; fa[1] = 4'd9; fa[2] = 4'd3;
        fd[0] = 32'hAA; fd[1] = 32'hBB; fd[2] = 32'hCC;
        tick();
        chk("byp_youngest", out_a, 32'hAA);
        fwd_valid = 3'b100;
        tick();
        chk("byp_fwd2", out_a, 32'hCC);
        fwd_valid = 3'b000;
        tick();
        chk("byp_regfile", out_a, 32'h1111_1111);

        // Load-use stall on rs2 = 5 for two cycles
        inst_in   = 32'h0001_4000;
        fwd_valid = 3'b001;
        fwd_busy  = 3'b001;
        fa[0] = 4'd5;
        fd[0] = 32'h55;
        #1;
        chk("lu_ready_c1", 32'(in_ready), 32'h0);
        tick();
        chk("lu_bubble_c1", 32'(out_valid), 32'h0);
        #1;
        chk("lu_ready_c2", 32'(in_ready), 32'h0);
        tick();
        chk("lu_bubble_c2", 32'(out_valid), 32'h0);
        fwd_busy = 3'b000;
        #1;
        chk("lu_ready_c3", 32'(in_ready), 32'h1);
        tick();
        chk("lu_valid", 32'(out_valid), 32'h1);
        chk("lu_op2", out_op2, 32'h55);
        chk("lu_b", out_b, 32'h55);

        // Backpressure holds outputs, then flush discards the incoming instruction
        fwd_valid = '0;
        pc_in     = 32'h200;
        inst_in   = 32'h0000_1234;
        tick();
        chk("bp_capture_pc", out_pc, 32'h200);
        out_ready = 1'b0;
        pc_in     = 32'h300;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready_low", 32'(in_ready), 32'h0);
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_pc", out_pc, 32'h200);
            chk("bp_hold_inst", out_inst, 32'h0000_1234);
        end
        flush = 1'b1;
        #1;
        chk("fl_ready_low", 32'(in_ready), 32'h0);
        tick();
        chk("fl_valid_clear", 32'(out_valid), 32'h0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_still_empty", 32'(out_valid), 32'h0);
        chk("fl_no_capture_pc", out_pc, 32'h200);

        // Asynchronous reset while holding an instruction
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc_in     = 32'h400;
        tick();
        chk("ar_held_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_pc", out_pc, 32'h0);
        chk("ar_inst", out_inst, 32'h0);
        chk("ar_a", out_a, 32'h0);
        #2;
        rst_n     = 1'b1;
        pc_in     = 32'h500;
        out_ready = 1'b1;
        tick();
        chk("ar_first_capture", 32'(out_valid), 32'h1);
        chk("ar_first_pc", out_pc, 32'h500);

        // Randomized run from a clean reset
        set_idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        m_valid = 1'b0;
        m_pc = '0; m_inst = '0; m_ctrl = '0; m_a = '0;
        m_b = '0; m_op2 = '0; m_immx = '0; m_bt = '0;
        for (int n = 0; n < 400; n++) begin
            inst_in   = $urandom;
            ctrl_in   = CTRL_W'($urandom);
            pc_in     = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NUM_FWD; i++) begin
                case ($urandom_range(0, 3))
                    0: fa[i] = inst_in[21:18];
                    1: fa[i] = inst_in[17:14];
                    2: fa[i] = inst_in[25:22];
                    default: fa[i] = 4'hF;
                endcase
                fd[i]        = $urandom;
                fwd_valid[i] = ($urandom_range(0, 3) != 0);
                fwd_busy[i]  = ($urandom_range(0, 5) == 0);
            end
            #1;
            model_cycle();
            tick();
            check_outputs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
